vending_machine_param: RTL and testbench

- Parametrised successor to the single-coin cola vending state machine.
- Accepts half-unit and one-unit coins against a configurable price, and vends one cola per completed purchase.
- Returns change as a train of half-unit pulses; supports buyer cancel/refund.
- Sits between the debounced coin/button inputs and the dispense/change-return actuator drivers.

---
 rtl/vending_machine_param.sv | 143 ++++++++++++++
 tb/tb_vending_machine_param.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_param.sv
// Parametrised cola vending FSM: half/one-unit coins, change paid as half-unit pulses, cancel refund.
// Optional idle-timeout auto-refund enabled by defining VM_TIMEOUT_EN.
module vending_machine_param #(
  parameter int unsigned PRICE       = 5,
  parameter int unsigned CREDIT_W    = 4,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned TMR_W       = 10
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                pi_money_half,
  input  logic                pi_money_one,
  input  logic                pi_cancel,
  output logic                po_cola,
  output logic                po_change,
  output logic                po_reject,
  output logic                po_busy,
  output logic [CREDIT_W-1:0] po_credit
);

  typedef enum logic [1:0] {StIdle, StAccum, StVend, StRefund} state_e;

  localparam logic [CREDIT_W-1:0] LP_PRICE = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] LP_ONE   = CREDIT_W'(1);

  state_e              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] r_chg;
  logic                r_cola;
  logic                r_change;
  logic                r_reject;
  logic                r_busy;

  logic [1:0]          w_add;
  logic [CREDIT_W-1:0] w_sum;
  logic                w_coin;
  logic                w_timeout;

  // Coin value in half-units: half=1, one=2, both=3.
  assign w_add  = {pi_money_one, pi_money_half};
  assign w_sum  = r_credit + CREDIT_W'(w_add);
  assign w_coin = pi_money_half | pi_money_one;

`ifdef VM_TIMEOUT_EN
  logic [TMR_W-1:0] r_tmr;

  assign w_timeout = (r_state == StAccum) && (r_tmr == TMR_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_tmr <= '0;
    end else if ((r_state == StAccum) && !w_coin && !pi_cancel && !w_timeout) begin
      r_tmr <= r_tmr + TMR_W'(1);
    end else begin
      r_tmr <= '0;
    end
  end
`else
  logic [TMR_W-1:0] w_unused_tmr;

  assign w_timeout    = 1'b0;
  assign w_unused_tmr = TMR_W'(TIMEOUT_CYC);
`endif

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state  <= StIdle;
      r_credit <= '0;
      r_chg    <= '0;
      r_cola   <= 1'b0;
      r_change <= 1'b0;
      r_reject <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_cola   <= 1'b0;
      r_change <= 1'b0;
      r_reject <= 1'b0;
      unique case (r_state)
        StIdle, StAccum: begin
          r_busy <= 1'b0;
          if (w_coin) begin
            // Coin is added before cancel is considered; reaching the price always vends.
            if (w_sum >= LP_PRICE) begin
              r_state  <= StVend;
              r_credit <= '0;
              r_chg    <= w_sum - LP_PRICE;
              r_cola   <= 1'b1;
              r_busy   <= 1'b1;
            end else if ((r_state == StAccum) && pi_cancel) begin
              r_state  <= StRefund;
              r_credit <= '0;
              r_chg    <= w_sum;
              r_change <= 1'b1;
              r_busy   <= 1'b1;
            end else begin
              r_state  <= StAccum;
              r_credit <= w_sum;
            end
          end else if ((r_state == StAccum) && (pi_cancel || w_timeout)) begin
            r_state  <= StRefund;
            r_credit <= '0;
            r_chg    <= r_credit;
            r_change <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        StVend: begin
          r_reject <= w_coin;
          if (r_chg != '0) begin
            r_state  <= StRefund;
            r_change <= 1'b1;
            r_busy   <= 1'b1;
          end else begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        end
        StRefund: begin
          r_reject <= w_coin;
          r_chg    <= (r_chg == '0) ? '0 : r_chg - LP_ONE;
          if (r_chg <= LP_ONE) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end else begin
            r_change <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign po_cola   = r_cola;
  assign po_change = r_change;
  assign po_reject = r_reject;
  assign po_busy   = r_busy;
  assign po_credit = r_credit;

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed self-checking bench for vending_machine_param (PRICE=5, CREDIT_W=4).
// The timeout scenario is exercised only when VM_TIMEOUT_EN is defined.
module tb_vending_machine_param;

  logic       sys_clk;
  logic       sys_rst;
  logic       pi_money_half;
  logic       pi_money_one;
  logic       pi_cancel;
  logic       po_cola;
  logic       po_change;
  logic       po_reject;
  logic       po_busy;
  logic [3:0] po_credit;

  int n_tot;
  int n_bad;

  vending_machine_param #(
    .PRICE      (5),
    .CREDIT_W   (4),
    .TIMEOUT_CYC(8),
    .TMR_W      (4)
  ) u_dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .pi_money_half(pi_money_half),
    .pi_money_one (pi_money_one),
    .pi_cancel    (pi_cancel),
    .po_cola      (po_cola),
    .po_change    (po_change),
    .po_reject    (po_reject),
    .po_busy      (po_busy),
    .po_credit    (po_credit)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tot++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge take them, sample 1ns after the edge.
  task automatic step(input logic h, input logic o, input logic c);
    pi_money_half = h;
    pi_money_one  = o;
    pi_cancel     = c;
    @(posedge sys_clk);
    #1;
    pi_money_half = 1'b0;
    pi_money_one  = 1'b0;
    pi_cancel     = 1'b0;
  endtask

  // Packs outputs as {cola, change, reject, busy, credit[3:0]}.
  function automatic int outs();
    return {po_cola, po_change, po_reject, po_busy, po_credit};
  endfunction

  function automatic int pk(input int cola, input int chg, input int rej, input int busy,
                            input int credit);
    return (cola << 7) | (chg << 6) | (rej << 5) | (busy << 4) | credit;
  endfunction

  initial begin
    n_tot = 0;
    n_bad = 0;
    pi_money_half = 1'b0;
    pi_money_one  = 1'b0;
    pi_cancel     = 1'b0;
    sys_rst       = 1'b0;
    #23;
    chk("reset_outs", outs(), 0);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    chk("post_reset_idle", outs(), 0);

    // Cancel in IDLE is ignored.
    step(0, 0, 1);
    chk("idle_cancel", outs(), 0);

    // Five half coins: credit 1..4, then vend with no change.
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 0);
      chk($sformatf("half_credit_%0d", i), outs(), pk(0, 0, 0, 0, i));
    end
    step(1, 0, 0);
    chk("t1_vend", outs(), pk(1, 0, 0, 1, 0));
    step(1, 0, 0);
    chk("t1_vend_exit", outs(), pk(0, 0, 1, 0, 0));
    step(0, 0, 0);
    chk("t1_idle", outs(), 0);

    // Credit 4 + one-unit coin: vend then one change pulse.
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    chk("t2_credit4", outs(), pk(0, 0, 0, 0, 4));
    step(0, 1, 0);
    chk("t2_vend", outs(), pk(1, 0, 0, 1, 0));
    step(0, 0, 0);
    chk("t2_chg1", outs(), pk(0, 1, 0, 1, 0));
    step(0, 0, 0);
    chk("t2_idle", outs(), 0);

    // Credit 4 + both coins (sum 7): vend then two change pulses.
    for (int i = 0; i < 2; i++) step(0, 1, 0);
    chk("t3_credit4", outs(), pk(0, 0, 0, 0, 4));
    step(1, 1, 0);
    chk("t3_vend", outs(), pk(1, 0, 0, 1, 0));
    step(0, 0, 0);
    chk("t3_chg1", outs(), pk(0, 1, 0, 1, 0));
    step(0, 0, 0);
    chk("t3_chg2", outs(), pk(0, 1, 0, 1, 0));
    step(0, 0, 0);
    chk("t3_idle", outs(), 0);

    // Credit 3 cancel: three pulses, coin during refund is rejected.
    step(0, 1, 0);
    step(1, 0, 0);
    chk("t4_credit3", outs(), pk(0, 0, 0, 0, 3));
    step(0, 0, 1);
    chk("t4_ref1", outs(), pk(0, 1, 0, 1, 0));
    step(1, 0, 0);
    chk("t4_ref2_rej", outs(), pk(0, 1, 1, 1, 0));
    step(0, 0, 0);
    chk("t4_ref3", outs(), pk(0, 1, 0, 1, 0));
    step(0, 0, 0);
    chk("t4_idle", outs(), 0);

    // Credit 4, cancel + half coin on same edge: vend wins, no change.
    step(0, 1, 0);
    step(0, 1, 0);
    step(1, 0, 1);
    chk("t5_vend", outs(), pk(1, 0, 0, 1, 0));
    step(0, 0, 0);
    chk("t5_idle", outs(), 0);

    // Cancel + coin below price refunds the full sum (1 + 1 = 2 pulses).
    step(1, 0, 0);
    step(1, 0, 1);
    chk("t6_ref1", outs(), pk(0, 1, 0, 1, 0));
    step(0, 0, 0);
    chk("t6_ref2", outs(), pk(0, 1, 0, 1, 0));
    step(0, 0, 0);
    chk("t6_idle", outs(), 0);

    // Reset mid-REFUND: outputs drop asynchronously, pending change lost.
    step(0, 1, 0);
    step(0, 0, 1);
    chk("t7_in_refund", outs(), pk(0, 1, 0, 1, 0));
    #2;
    sys_rst = 1'b0;
    #1;
    chk("t7_async_rst", outs(), 0);
    #3;
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    chk("t7_after_rel", outs(), 0);
    step(0, 0, 0);
    chk("t7_no_change", outs(), 0);
    step(1, 0, 0);
    chk("t7_new_coin", outs(), pk(0, 0, 0, 0, 1));
    step(0, 0, 1);
    step(0, 0, 0);
    chk("t7_cleanup", outs(), 0);

`ifdef VM_TIMEOUT_EN
    // Credit 2 idle for 8 cycles triggers a two-pulse refund.
    step(1, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0);
    chk("to_before", outs(), pk(0, 0, 0, 0, 2));
    step(0, 0, 0);
    chk("to_ref1", outs(), pk(0, 1, 0, 1, 0));
    step(0, 0, 0);
    chk("to_ref2", outs(), pk(0, 1, 0, 1, 0));
    step(0, 0, 0);
    chk("to_idle", outs(), 0);

    // A coin at idle cycle 6 restarts the timer; no refund 7 cycles later.
    step(1, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0);
    chk("to_restart", outs(), pk(0, 0, 0, 0, 3));
    step(0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    chk("to_cleanup", outs(), 0);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
